uart_rx: RTL and testbench

- UART receiver: the receive-side counterpart of the chip's UART transmitter, sharing its frame format and divider constants.
- Frame: 8N1, LSB first, idle-high line, one start bit (0), one stop bit (1).
- Deserialises the asynchronous `rx` pin into a byte and presents it to the UART register block with a one-cycle completion strobe.
- Sits beside `uart_tx` under the UART top; both run from the same system clock and the same baud divisor.

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_rx_if.sv | 13 +
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 113 +++++++++++
 tb/tb_uart_rx.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART constants and receiver state encoding.
package uart_rx_pkg;

  localparam int       BYTE_DATA_W      = 8;
  localparam int       UART_DIV_RATE    = 433;   // bit period - 1 at 50 MHz / 115200 baud
  localparam int       UART_DIV_CNT_W   = 9;
  localparam logic     UART_START_BIT   = 1'b0;
  localparam logic     UART_STOP_BIT    = 1'b1;
  localparam int       UART_BIT_CNT_MSB = 2;     // counts the 8 data bits

  typedef enum logic [1:0] {
    UART_RX_STATE_IDLE  = 2'd0,
    UART_RX_STATE_START = 2'd1,
    UART_RX_STATE_DATA  = 2'd2,
    UART_RX_STATE_STOP  = 2'd3
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-register-block bus: status, completion strobe and received byte.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                   rx_busy;
  logic                   rx_end;
  logic [BYTE_DATA_W-1:0] rx_data;
  logic                   rx_frame_err;

  modport master (output rx_busy, output rx_end, output rx_data, output rx_frame_err);
  modport slave  (input  rx_busy, input  rx_end, input  rx_data, input  rx_frame_err);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous pad input; resets to 1 (idle line).
module uart_sync (
  input  logic clk,
  input  logic reset_,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      // NOTE: non-blocking so both stages update from pre-edge values and form a real 2-deep pipeline.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling via a baud divider, LSB-first deserialiser.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DIV_RATE  = UART_DIV_RATE,
  parameter int DIV_CNT_W = UART_DIV_CNT_W
) (
  input  logic     clk,
  input  logic     reset_,
  input  logic     rx,
  uart_rx_if.master bus
);

  localparam logic [DIV_CNT_W-1:0]        DIV_FULL = DIV_CNT_W'(DIV_RATE);
  localparam logic [DIV_CNT_W-1:0]        DIV_HALF = DIV_CNT_W'(DIV_RATE / 2);
  localparam logic [UART_BIT_CNT_MSB:0]   BIT_LAST = '1;

  logic                     rx_s;
  uart_rx_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0]     div_q,   div_d;
  logic [UART_BIT_CNT_MSB:0] bit_q,  bit_d;
  logic [BYTE_DATA_W-1:0]   shreg_q, shreg_d;
  logic                     end_q,   end_d;
  logic [BYTE_DATA_W-1:0]   data_q,  data_d;
  logic                     err_q,   err_d;

  uart_sync u_sync (
    .clk    (clk),
    .reset_ (reset_),
    .d      (rx),
    .q      (rx_s)
  );

  // State, divider, bit counter, shift register and output registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= UART_RX_STATE_IDLE;
      div_q   <= DIV_FULL;
      bit_q   <= '0;
      shreg_q <= '0;
      end_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      end_q   <= end_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: start detection, divider countdown and per-bit sampling.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a variable unassigned (no latches).
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    end_d   = 1'b0;
    data_d  = data_q;
    err_d   = err_q;

    if (state_q == UART_RX_STATE_IDLE) begin
      // Half-period load puts every later sample in the middle of its bit.
      if (rx_s == UART_START_BIT) begin
        state_d = UART_RX_STATE_START;
        div_d   = DIV_HALF;
      end
    end else if (div_q != '0) begin
      div_d = div_q - 1'b1;
    end else begin
      div_d = DIV_FULL;
      unique case (state_q)
        UART_RX_STATE_START: begin
          if (rx_s == UART_START_BIT) begin
            state_d = UART_RX_STATE_DATA;
            bit_d   = '0;
          end else begin
            // Start bit gone by mid-bit: line glitch, drop it silently.
            state_d = UART_RX_STATE_IDLE;
          end
        end
        UART_RX_STATE_DATA: begin
          shreg_d = {rx_s, shreg_q[BYTE_DATA_W-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = UART_RX_STATE_STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 1'b1;
          end
        end
        UART_RX_STATE_STOP: begin
          // Byte is handed over even when the stop bit is bad.
          end_d   = 1'b1;
          data_d  = shreg_q;
          err_d   = (rx_s != UART_STOP_BIT);
          state_d = UART_RX_STATE_IDLE;
          bit_d   = '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_busy      = (state_q != UART_RX_STATE_IDLE);
  assign bus.rx_end       = end_q;
  assign bus.rx_data      = data_q;
  assign bus.rx_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with an 8-cycle bit period.
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset_;
  logic rx;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  uart_rx_if u_if ();

  uart_rx #(.DIV_RATE(7), .DIV_CNT_W(3)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .rx     (rx),
    .bus    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion strobe must match the oldest pending frame, including its cycle.
  always @(negedge clk) begin
    if (u_if.rx_end === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rx_end: got rx_end=1 with no frame pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rx_data",      32'(u_if.rx_data),      32'(e.data));
        check("rx_frame_err", 32'(u_if.rx_frame_err), 32'(e.err));
        check("rx_end_cycle", 32'(cyc),               32'(e.cyc));
      end
    end
  end

  // Serialise one frame; entered and left on a falling edge. The line falls in cycle c0,
  // so rx_s falls at t = c0 + 2 and the strobe is due at t + 77.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit chk);
    logic [9:0] bits;
    exp_t       e;
    int         c0;
    bits   = {stop, d, 1'b0};
    c0     = cyc;
    e.data = d;
    e.err  = ~stop;
    e.cyc  = c0 + 79;
    sb_q.push_back(e);
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 0) rx = bits[b];
        if (chk && b == 0 && i == 1) check("busy_before_start", 32'(u_if.rx_busy), 32'd0);
        if (chk && b == 0 && i == 3) check("busy_at_t_plus_1",  32'(u_if.rx_busy), 32'd1);
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Two-cycle low pulse: rejected at the start-bit sample (t + 4).
  task automatic glitch();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("glitch_busy_t1", 32'(u_if.rx_busy), 32'd1);
    repeat (3) @(negedge clk);
    check("glitch_busy_t4", 32'(u_if.rx_busy), 32'd1);
    @(negedge clk);
    check("glitch_busy_t5", 32'(u_if.rx_busy), 32'd0);
    idle(10);
    check("glitch_data_kept", 32'(u_if.rx_data),      32'hA5);
    check("glitch_err_kept",  32'(u_if.rx_frame_err), 32'd0);
  endtask

  initial begin
    reset_ = 1'b0;
    rx     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy",  32'(u_if.rx_busy),      32'd0);
    check("reset_end",   32'(u_if.rx_end),       32'd0);
    check("reset_data",  32'(u_if.rx_data),      32'd0);
    check("reset_err",   32'(u_if.rx_frame_err), 32'd0);
    reset_ = 1'b1;
    idle(5);

    // Clean frame with busy timing.
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(5);

    glitch();

    // Framing error: byte still delivered.
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(20);
    check("err_frame_data", 32'(u_if.rx_data),      32'h3C);
    check("err_frame_flag", 32'(u_if.rx_frame_err), 32'd1);

    // Asynchronous reset in the middle of a frame discards it.
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("midframe_busy", 32'(u_if.rx_busy), 32'd1);
    #2 reset_ = 1'b0;
    #1;
    check("async_reset_busy", 32'(u_if.rx_busy),      32'd0);
    check("async_reset_end",  32'(u_if.rx_end),       32'd0);
    check("async_reset_data", 32'(u_if.rx_data),      32'd0);
    check("async_reset_err",  32'(u_if.rx_frame_err), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_ = 1'b1;
    idle(20);
    check("post_reset_busy", 32'(u_if.rx_busy), 32'd0);
    check("post_reset_data", 32'(u_if.rx_data), 32'd0);

    // Back-to-back frames with no idle gap: strobes 80 cycles apart.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(10);

    // Transmitter-style byte stream.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(5);

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
